// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pkg
//  Description : Shared VGA constants: 640x480@60 timing defaults, framebuffer
//                geometry (160x120, 3-bit colour) and the framebuffer address
//                helper used by both the scanout and the plot-side writer.
//  Revision    : 1.0  initial release
// ============================================================================
package vga_pkg;

    // 640x480@60 timing, horizontal in pixel ticks, vertical in lines
    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FP_DEF      = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BP_DEF      = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FP_DEF      = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BP_DEF      = 33;

    // Framebuffer geometry
    localparam int FB_W       = 160;
    localparam int FB_H       = 120;
    localparam int FB_SIZE    = FB_W * FB_H;
    localparam int FB_ADDR_W  = 15;
    localparam int FB_COLOR_W = 3;

    // Screen counter width; covers totals up to 1023 (800 / 525 by default)
    localparam int CNT_W = 10;

    // Row-major framebuffer address y*160 + x; 160 = 128 + 32 so the
    // multiply reduces to two shifts and an add.
    function automatic logic [FB_ADDR_W-1:0] fb_addr(
        input logic [FB_ADDR_W-1:0] x,
        input logic [FB_ADDR_W-1:0] y
    );
        return (y << 7) + (y << 5) + x;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_scanout_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_scanout_if
//  Description : Framebuffer read port. The master (scanout) drives rd_addr;
//                the slave (synchronous RAM) returns rd_data one clock later.
//  Ports       : rd_addr [14:0] read address, rd_data [2:0] colour {R,G,B}
//  Revision    : 1.0  initial release
// ============================================================================
interface vga_scanout_if;
    import vga_pkg::*;

    logic [FB_ADDR_W-1:0]  rd_addr;
    logic [FB_COLOR_W-1:0] rd_data;

    modport master (output rd_addr, input rd_data);
    modport slave  (input rd_addr, output rd_data);

endinterface
`default_nettype wire

// File: rtl/vga_timing.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing
//  Description : Pixel-tick generator (clock/2), horizontal and vertical
//                counters, raw active-low syncs, active-video flag,
//                registered vblank and a one-clock frame_start pulse.
//  Ports       : clock, reset (async, active low) in;
//                pix_en, hcount, vcount, active, hsync_raw, vsync_raw,
//                frame_start, vblank out
//  Revision    : 1.0  initial release
// ============================================================================
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FP      = H_FP_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BP      = H_BP_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FP      = V_FP_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BP      = V_BP_DEF
) (
    input  logic             clock,
    input  logic             reset,
    output logic             pix_en,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             active,
    output logic             hsync_raw,
    output logic             vsync_raw,
    output logic             frame_start,
    output logic             vblank
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS      = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS      = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_VISIBLE + H_FP);
    localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_VISIBLE + V_FP);
    localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_VISIBLE + V_FP + V_SYNC);

    logic             phase;
    logic             h_wrap;
    logic [CNT_W-1:0] h_next;
    logic [CNT_W-1:0] v_next;

    // Phase is 0 out of reset, so the first tick lands on the second clock.
    assign pix_en = phase;

    always_comb begin
        h_wrap = (hcount == H_LAST);
        h_next = h_wrap ? '0 : hcount + 1'b1;
        v_next = vcount;
        if (h_wrap) begin
            v_next = (vcount == V_LAST) ? '0 : vcount + 1'b1;
        end
    end

    assign active    = (hcount < H_VIS) && (vcount < V_VIS);
    assign hsync_raw = ~((hcount >= HS_START) && (hcount < HS_END));
    assign vsync_raw = ~((vcount >= VS_START) && (vcount < VS_END));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            phase       <= 1'b0;
            hcount      <= '0;
            vcount      <= '0;
            frame_start <= 1'b0;
            vblank      <= 1'b0;
        end else begin
            phase       <= ~phase;
            frame_start <= 1'b0;
            if (pix_en) begin
                hcount      <= h_next;
                vcount      <= v_next;
                // vblank and frame_start track the counter values being loaded
                vblank      <= (v_next >= V_VIS);
                frame_start <= h_wrap && (v_next == V_VIS);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_scanout.sv
`default_nettype none
// ============================================================================
//  Module      : vga_scanout
//  Description : Scans a 160x120 3-bit framebuffer out to a VGA DAC with
//                2^SCALE_LOG2 pixel replication. Address, RAM read and colour
//                form a two-tick pipeline; syncs and blank are delayed to match.
//  Ports       : clock, reset (async, active low) in;
//                fb (vga_scanout_if.master) framebuffer read port;
//                VGA_R/G/B [3:0], VGA_HS, VGA_VS, VGA_BLANK, VGA_SYNC,
//                VGA_CLK, frame_start, vblank out
//  Revision    : 1.0  initial release
// ============================================================================
module vga_scanout
    import vga_pkg::*;
#(
    parameter int H_VISIBLE  = H_VISIBLE_DEF,
    parameter int H_FP       = H_FP_DEF,
    parameter int H_SYNC     = H_SYNC_DEF,
    parameter int H_BP       = H_BP_DEF,
    parameter int V_VISIBLE  = V_VISIBLE_DEF,
    parameter int V_FP       = V_FP_DEF,
    parameter int V_SYNC     = V_SYNC_DEF,
    parameter int V_BP       = V_BP_DEF,
    parameter int SCALE_LOG2 = 2
) (
    input  logic         clock,
    input  logic         reset,
    vga_scanout_if.master fb,
    output logic [3:0]   VGA_R,
    output logic [3:0]   VGA_G,
    output logic [3:0]   VGA_B,
    output logic         VGA_HS,
    output logic         VGA_VS,
    output logic         VGA_BLANK,
    output logic         VGA_SYNC,
    output logic         VGA_CLK,
    output logic         frame_start,
    output logic         vblank
);

    logic             pix_en;
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             active;
    logic             hsync_raw;
    logic             vsync_raw;

    logic [FB_ADDR_W-1:0] fb_x;
    logic [FB_ADDR_W-1:0] fb_y;

    // First delay stage for the signals that travel alongside the RAM read
    logic act_d1;
    logic hs_d1;
    logic vs_d1;

    vga_timing #(
        .H_VISIBLE (H_VISIBLE),
        .H_FP      (H_FP),
        .H_SYNC    (H_SYNC),
        .H_BP      (H_BP),
        .V_VISIBLE (V_VISIBLE),
        .V_FP      (V_FP),
        .V_SYNC    (V_SYNC),
        .V_BP      (V_BP)
    ) u_timing (
        .clock       (clock),
        .reset       (reset),
        .pix_en      (pix_en),
        .hcount      (hcount),
        .vcount      (vcount),
        .active      (active),
        .hsync_raw   (hsync_raw),
        .vsync_raw   (vsync_raw),
        .frame_start (frame_start),
        .vblank      (vblank)
    );

    assign fb_x = FB_ADDR_W'(hcount >> SCALE_LOG2);
    assign fb_y = FB_ADDR_W'(vcount >> SCALE_LOG2);

    assign VGA_SYNC = 1'b0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fb.rd_addr <= '0;
            act_d1     <= 1'b0;
            hs_d1      <= 1'b1;
            vs_d1      <= 1'b1;
            VGA_R      <= 4'h0;
            VGA_G      <= 4'h0;
            VGA_B      <= 4'h0;
            VGA_HS     <= 1'b1;
            VGA_VS     <= 1'b1;
            VGA_BLANK  <= 1'b0;
            VGA_CLK    <= 1'b1;
        end else begin
            // Registered inverse of next pix_en: DAC edge lands mid-pixel
            VGA_CLK <= pix_en;
            if (pix_en) begin
                // Address holds through blanking, so the RAM sees no
                // spurious reads outside the visible area.
                if (active) begin
                    fb.rd_addr <= fb_addr(fb_x, fb_y);
                end
                act_d1    <= active;
                hs_d1     <= hsync_raw;
                vs_d1     <= vsync_raw;
                // rd_data belongs to the address issued one tick earlier,
                // which matches the stage-1 flags.
                VGA_HS    <= hs_d1;
                VGA_VS    <= vs_d1;
                VGA_BLANK <= act_d1;
                VGA_R     <= act_d1 ? {4{fb.rd_data[2]}} : 4'h0;
                VGA_G     <= act_d1 ? {4{fb.rd_data[1]}} : 4'h0;
                VGA_B     <= act_d1 ? {4{fb.rd_data[0]}} : 4'h0;
            end
        end
    end

endmodule
`default_nettype wire
